ls_exec: RTL and testbench
==========================

# ls_exec

Load/store execution unit that sits directly downstream of the load/store buffer. It accepts one ready memory operation at a time, computes the effective address, and performs the access byte-serially through the shared memory arbiter. Load results are broadcast to the ROB/CDB. Stores are held until the ROB signals that the store is at its head, then written, then acknowledged.

## Interface
- Parameters:
  - ADDR_W, 32, address width (`addrWidth`)
  - DATA_W, 32, data width (`dataWidth`)
- Ports:
  - clk  in  1  clock; all state updates on the rising edge
  - rst  in  1  reset, asynchronous, active-low (rst=0 resets immediately)
  - rdy  in  1  global enable; when 0, all state and outputs hold
  - clear  in  1  misprediction flush, synchronous
  - in_valid  in  1  LSB presents an operation this cycle
  - op_type_in  in  `opTypeWidth  one of LB/LH/LW/LBU/LHU/SB/SH/SW
  - rs1_in, rs2_in  in  DATA_W  base register and store data
  - imm_in  in  `immWidth  sign-extended offset
  - tag_in  in  `tagWidth  ROB destination tag
  - busy  out  1  unit cannot accept; LSB must not issue while 1
  - rob_head_tag  in  `tagWidth  tag currently at ROB head
  - mem_req  out  1  request for the memory port
  - mem_gnt  in  1  arbiter grant; held by the arbiter until mem_req falls
  - mem_a  out  ADDR_W  byte address
  - mem_wr  out  1  1 = write this cycle
  - mem_dout  out  8  write byte
  - mem_din  in  8  read byte, valid the cycle after its address
  - cdb_valid  out  1  one-cycle load-result pulse
  - cdb_tag  out  `tagWidth  tag of the result
  - cdb_data  out  DATA_W  extended load value
  - store_done  out  1  one-cycle pulse when a store's last byte is written
  - store_tag  out  `tagWidth  tag of the completed store

## Operation
- States: IDLE, WAIT_COMMIT, LOAD, STORE, DONE.
- IDLE:
  - busy=0. On in_valid&rdy, latch the operation and set addr = rs1_in + imm_in (mod 2^32).
  - Byte count: 1 (B/BU), 2 (H/HU), 4 (W).
  - Next state: LOAD for loads, WAIT_COMMIT for stores.
- WAIT_COMMIT: wait until rob_head_tag == latched tag, then go to STORE.
- LOAD:
  - mem_req=1. In each granted cycle, drive mem_a = addr + issue_cnt and mem_wr=0, then increment issue_cnt.
  - Capture mem_din into byte lane recv_cnt on the following cycle. Bytes are little-endian.
  - After the last byte is captured: drop mem_req and go to DONE.
- STORE:
  - mem_req=1. In each granted cycle, drive mem_wr=1, mem_a = addr + cnt, mem_dout = rs2 byte cnt.
  - After the last byte is written: drop mem_req and go to DONE.
- DONE, for one cycle:
  - Loads: cdb_valid=1 with cdb_data set as follows. LB/LH are sign-extended. LBU/LHU are zero-extended. LW is the full word.
  - Stores: store_done=1.
  - Next state: IDLE.
- busy=1 in every state except IDLE. Accepting an operation in IDLE sets busy in the next cycle.
- Misaligned addresses are legal. Bytes are accessed sequentially, and address wrap at 2^32 is natural.
- clear:
  - In IDLE, WAIT_COMMIT, LOAD or DONE-of-load: return to IDLE, mem_req=0, no cdb pulse. For a LOAD, the arbiter sees mem_req fall and the pending read byte is discarded.
  - In STORE or DONE-of-store: ignored, because the store is committed. The remaining bytes are written and store_done still pulses.
  - clear together with in_valid: the operation is not accepted.
- Any operation sampled while busy=1 is ignored.
- Reset values: state=IDLE, busy=0, mem_req=0, mem_wr=0, mem_a=0, mem_dout=0, cdb_valid=0, cdb_tag=0, cdb_data=0, store_done=0, store_tag=0; counters cleared.

## Timing
- Accept edge = cycle 0. The numbers below assume mem_gnt is asserted as soon as mem_req is.
- Loads:
  - mem_req rises in cycle 1. Addresses are presented in cycles 1..N.
  - Data is captured in cycles 2..N+1. cdb_valid is in cycle N+2.
  - LB: cdb in cycle 3. LH: cycle 4. LW: cycle 6.
- Stores (N = byte count):
  - The matching rob_head_tag is seen in WAIT_COMMIT at cycle k.
  - Writes occur in cycles k+1..k+N. store_done is in cycle k+N+1.
  - If the tag already matches in cycle 1, SW store_done is in cycle 6.
- A cycle with mem_gnt=0 while in LOAD/STORE issues nothing; counters hold.
- rdy=0 freezes everything, including pending read capture. The arbiter and RAM freeze in the same way.
- cdb_valid and store_done are high for exactly one rdy-qualified cycle. They are never both high.

## Test plan
- LW, rs1=0x1000, imm=-4, RAM[0xFFC..0xFFF]=78 56 34 12 -> mem_a 0xFFC..0xFFF in cycles 1–4; cdb_valid in cycle 6 with data 0x12345678 and tag_in.
- LB and LBU at a byte holding 0x80 -> cdb_data 0xFFFFFF80 and 0x00000080 respectively, each in cycle 3.
- SH, rs2=0xABCD, addr 0x2001, ROB head matches 3 cycles after accept -> writes CD to 0x2001 then AB to 0x2002; store_done one cycle after the last write.
- mem_gnt toggled 1,0,1,1,0,1 during LW -> exactly 4 addresses issued in order; correct word on the CDB.
- clear during LOAD byte 2 -> mem_req falls, no cdb pulse, busy=0 next cycle. clear during STORE -> all bytes still written and store_done pulses.
- rst driven low mid-LW (asynchronous, between edges) -> every output immediately at its reset value. After release, a new LB completes normally.

Source files
------------

// File: rtl/ls_exec.sv
// ls_exec: byte-serial load/store execution unit between the load/store buffer and the memory arbiter
module ls_exec #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [2:0]        op_type_in,
  input  logic [DATA_W-1:0] rs1_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              busy,
  input  logic [TAG_W-1:0]  rob_head_tag,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              store_done,
  output logic [TAG_W-1:0]  store_tag
);
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SB = 3'd5, SH = 3'd6;
  typedef enum logic [2:0] {IDLE, WAIT_COMMIT, LOAD, STORE, DONE} state_t;
  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [2:0]        cnt_q, cnt_d, recv_q, recv_d;
  logic              pend_q, pend_d;
  logic [2:0]        n, last;
  logic              is_load, issue;
  logic [DATA_W-1:0] ext;

  assign n = (op_q == LB || op_q == LBU || op_q == SB) ? 3'd1 :
             (op_q == LH || op_q == LHU || op_q == SH) ? 3'd2 : 3'd4;
  assign last = n - 3'd1;
  assign is_load = op_q <= LHU;
  assign issue = mem_gnt && ((state_q == LOAD && cnt_q < n) || state_q == STORE);
  assign ext = op_q == LB  ? DATA_W'($signed(data_q[7:0]))  :
               op_q == LH  ? DATA_W'($signed(data_q[15:0])) :
               op_q == LBU ? DATA_W'(data_q[7:0])           :
               op_q == LHU ? DATA_W'(data_q[15:0])          : data_q;

  assign busy       = state_q != IDLE;
  assign mem_req    = state_q == LOAD || state_q == STORE;
  assign mem_wr     = issue && state_q == STORE;
  assign mem_a      = issue ? addr_q + ADDR_W'(cnt_q) : '0;
  assign mem_dout   = mem_wr ? data_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  assign cdb_valid  = state_q == DONE && is_load && !(clear && rdy);
  assign cdb_tag    = cdb_valid ? tag_q : '0;
  assign cdb_data   = cdb_valid ? ext : '0;
  assign store_done = state_q == DONE && !is_load;
  assign store_tag  = store_done ? tag_q : '0;

  // next state: accept, wait for commit, issue/capture bytes, one-cycle completion
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    recv_d  = recv_q;
    pend_d  = pend_q;
    if (rdy) begin
      case (state_q)
        IDLE: if (in_valid && !clear) begin
          op_d    = op_type_in;
          addr_d  = ADDR_W'(rs1_in) + ADDR_W'($signed(imm_in));
          data_d  = op_type_in <= LHU ? '0 : rs2_in;
          tag_d   = tag_in;
          cnt_d   = 3'd0;
          recv_d  = 3'd0;
          pend_d  = 1'b0;
          state_d = op_type_in <= LHU ? LOAD : WAIT_COMMIT;
        end
        WAIT_COMMIT: state_d = clear ? IDLE : rob_head_tag == tag_q ? STORE : WAIT_COMMIT;
        LOAD: if (clear) begin
          state_d = IDLE;
          pend_d  = 1'b0;
        end else begin
          pend_d = issue;
          cnt_d  = cnt_q + {2'b00, issue};
          if (pend_q) begin
            data_d[{recv_q[1:0], 3'b000} +: 8] = mem_din;
            recv_d  = recv_q + 3'd1;
            state_d = recv_q == last ? DONE : LOAD;
          end
        end
        STORE: if (issue) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = cnt_q == last ? DONE : STORE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      cnt_q   <= 3'd0;
      recv_q  <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      recv_q  <= recv_d;
      pend_q  <= pend_d;
    end
  end
endmodule

// File: tb/tb_ls_exec.sv
// tb_ls_exec: scoreboard bench for ls_exec with a byte RAM and a gated arbiter model
module tb_ls_exec;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4, SH = 3'd6, SW = 3'd7;
  typedef struct packed {logic [31:0] a; logic wr; logic [7:0] d; logic [31:0] c;} bus_t;
  typedef struct packed {logic [3:0] tag; logic [31:0] d; logic [31:0] c;} res_t;

  logic clk = 0, rst, rdy, clear, in_valid, gnt_en;
  logic [2:0] op_type_in;
  logic [31:0] rs1_in, rs2_in, imm_in;
  logic [3:0] tag_in, rob_head_tag;
  logic busy, mem_req, mem_gnt, mem_wr, cdb_valid, store_done;
  logic [31:0] mem_a, cdb_data;
  logic [7:0] mem_dout, mem_din;
  logic [3:0] cdb_tag, store_tag;
  logic [7:0] ram [0:65535];
  int cyc = 0, acc = 0, n_chk = 0, n_fail = 0;
  bus_t exp_bus[$], got_bus[$];
  res_t exp_cdb[$], got_cdb[$], exp_sd[$], got_sd[$];

  ls_exec dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .in_valid(in_valid),
    .op_type_in(op_type_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .tag_in(tag_in), .busy(busy), .rob_head_tag(rob_head_tag), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .store_done(store_done), .store_tag(store_tag)
  );

  always #5 clk = ~clk;
  assign mem_gnt = mem_req & gnt_en;

  // RAM returns the addressed byte one cycle later and freezes with rdy
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rdy && mem_req && mem_gnt && !mem_wr) mem_din <= ram[mem_a[15:0]];
  end

  // monitor: address 0 is never used by the tests, so a zero mem_a read is an idle slot
  always @(negedge clk) if (rst && rdy) begin
    if (mem_req && mem_gnt && (mem_wr || mem_a != 0))
      got_bus.push_back('{mem_a, mem_wr, mem_wr ? mem_dout : 8'h00, 32'(cyc - acc + 1)});
    if (cdb_valid) got_cdb.push_back('{cdb_tag, cdb_data, 32'(cyc - acc + 1)});
    if (store_done) got_sd.push_back('{store_tag, 32'h0, 32'(cyc - acc + 1)});
  end

  task automatic sb_reset;
    exp_bus.delete(); got_bus.delete(); exp_cdb.delete(); got_cdb.delete(); exp_sd.delete(); got_sd.delete();
  endtask

  task automatic issue_op(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] imm,
                          input logic [31:0] rs2, input logic [3:0] tag);
    @(negedge clk);
    op_type_in = op; rs1_in = rs1; imm_in = imm; rs2_in = rs2; tag_in = tag; in_valid = 1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset;
    rst = 1; #2 rst = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, mem_req, mem_wr, mem_a, mem_dout, cdb_valid, cdb_tag, cdb_data, store_done, store_tag} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got busy=%b req=%b a=%h cdb=%b", busy, mem_req, mem_a, cdb_valid);
    end
    @(negedge clk); rst = 1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_lw;
    sb_reset();
    for (int i = 0; i < 4; i++) exp_bus.push_back('{32'hFFC + i, 1'b0, 8'h00, 32'(i + 1)});
    exp_cdb.push_back('{4'd5, 32'h12345678, 32'd6});
    issue_op(LW, 32'h1000, 32'hFFFF_FFFC, 32'h0, 4'd5);
    n_chk++;
    if (busy !== 1'b1 || mem_req !== 1'b1) begin n_fail++; $display("FAIL lw_busy got busy=%b req=%b exp 1 1", busy, mem_req); end
    wait_idle(20);
    n_chk++;
    if (got_bus.size() != exp_bus.size()) begin n_fail++; $display("FAIL lw_bus_count got %0d exp %0d", got_bus.size(), exp_bus.size()); end
    foreach (exp_bus[i]) if (i < got_bus.size()) begin
      n_chk++;
      if (got_bus[i] !== exp_bus[i]) begin n_fail++; $display("FAIL lw_bus[%0d] got %h exp %h", i, got_bus[i], exp_bus[i]); end
    end
    n_chk++;
    if (got_cdb.size() != 1) begin n_fail++; $display("FAIL lw_cdb_count got %0d exp 1", got_cdb.size()); end
    else if (got_cdb[0] !== exp_cdb[0]) begin n_fail++; $display("FAIL lw_cdb got %h exp %h", got_cdb[0], exp_cdb[0]); end
  endtask

  task automatic test_ext;
    sb_reset();
    issue_op(LB, 32'h2F00, 32'h100, 32'h0, 4'd1);
    exp_bus.push_back('{32'h3000, 1'b0, 8'h00, 32'd1}); exp_cdb.push_back('{4'd1, 32'hFFFFFF80, 32'd3});
    wait_idle(20);
    issue_op(LBU, 32'h3010, 32'hFFFF_FFF0, 32'h0, 4'd2);
    exp_bus.push_back('{32'h3000, 1'b0, 8'h00, 32'd1}); exp_cdb.push_back('{4'd2, 32'h00000080, 32'd3});
    wait_idle(20);
    issue_op(LH, 32'h3000, 32'h0, 32'h0, 4'd3);
    exp_bus.push_back('{32'h3000, 1'b0, 8'h00, 32'd1}); exp_bus.push_back('{32'h3001, 1'b0, 8'h00, 32'd2});
    exp_cdb.push_back('{4'd3, 32'hFFFF9A80, 32'd4});
    wait_idle(20);
    issue_op(LHU, 32'h3000, 32'h0, 32'h0, 4'd4);
    exp_bus.push_back('{32'h3000, 1'b0, 8'h00, 32'd1}); exp_bus.push_back('{32'h3001, 1'b0, 8'h00, 32'd2});
    exp_cdb.push_back('{4'd4, 32'h00009A80, 32'd4});
    wait_idle(20);
    n_chk++;
    if (got_bus.size() != exp_bus.size()) begin n_fail++; $display("FAIL ext_bus_count got %0d exp %0d", got_bus.size(), exp_bus.size()); end
    foreach (exp_bus[i]) if (i < got_bus.size()) begin
      n_chk++;
      if (got_bus[i] !== exp_bus[i]) begin n_fail++; $display("FAIL ext_bus[%0d] got %h exp %h", i, got_bus[i], exp_bus[i]); end
    end
    n_chk++;
    if (got_cdb.size() != exp_cdb.size()) begin n_fail++; $display("FAIL ext_cdb_count got %0d exp %0d", got_cdb.size(), exp_cdb.size()); end
    foreach (exp_cdb[i]) if (i < got_cdb.size()) begin
      n_chk++;
      if (got_cdb[i] !== exp_cdb[i]) begin n_fail++; $display("FAIL ext_cdb[%0d] got %h exp %h", i, got_cdb[i], exp_cdb[i]); end
    end
  endtask

  task automatic test_sh;
    sb_reset();
    rob_head_tag = 4'hF;
    exp_bus.push_back('{32'h2001, 1'b1, 8'hCD, 32'd4}); exp_bus.push_back('{32'h2002, 1'b1, 8'hAB, 32'd5});
    exp_sd.push_back('{4'd3, 32'h0, 32'd6});
    issue_op(SH, 32'h2000, 32'h1, 32'h0000ABCD, 4'd3);
    repeat (2) begin @(posedge clk); #1; end
    n_chk++;
    if (busy !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL sh_wait got busy=%b req=%b exp 1 0", busy, mem_req); end
    rob_head_tag = 4'd3;
    wait_idle(20);
    rob_head_tag = 4'hF;
    n_chk++;
    if (got_bus.size() != exp_bus.size()) begin n_fail++; $display("FAIL sh_bus_count got %0d exp %0d", got_bus.size(), exp_bus.size()); end
    foreach (exp_bus[i]) if (i < got_bus.size()) begin
      n_chk++;
      if (got_bus[i] !== exp_bus[i]) begin n_fail++; $display("FAIL sh_bus[%0d] got %h exp %h", i, got_bus[i], exp_bus[i]); end
    end
    n_chk++;
    if (got_sd.size() != 1) begin n_fail++; $display("FAIL sh_done_count got %0d exp 1", got_sd.size()); end
    else if (got_sd[0] !== exp_sd[0]) begin n_fail++; $display("FAIL sh_done got %h exp %h", got_sd[0], exp_sd[0]); end
    n_chk++;
    if (got_cdb.size() != 0) begin n_fail++; $display("FAIL sh_no_cdb got %0d exp 0", got_cdb.size()); end
  endtask

  task automatic test_gnt_toggle;
    logic [4:0] pat;
    sb_reset();
    pat = 5'b10110;
    exp_bus.push_back('{32'h4010, 1'b0, 8'h00, 32'd1}); exp_bus.push_back('{32'h4011, 1'b0, 8'h00, 32'd3});
    exp_bus.push_back('{32'h4012, 1'b0, 8'h00, 32'd4}); exp_bus.push_back('{32'h4013, 1'b0, 8'h00, 32'd6});
    exp_cdb.push_back('{4'd6, 32'hCAFEF00D, 32'd8});
    issue_op(LW, 32'h4000, 32'h10, 32'h0, 4'd6);
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; gnt_en = pat[i]; end
    wait_idle(20);
    gnt_en = 1;
    n_chk++;
    if (got_bus.size() != exp_bus.size()) begin n_fail++; $display("FAIL gnt_bus_count got %0d exp %0d", got_bus.size(), exp_bus.size()); end
    foreach (exp_bus[i]) if (i < got_bus.size()) begin
      n_chk++;
      if (got_bus[i] !== exp_bus[i]) begin n_fail++; $display("FAIL gnt_bus[%0d] got %h exp %h", i, got_bus[i], exp_bus[i]); end
    end
    n_chk++;
    if (got_cdb.size() != 1) begin n_fail++; $display("FAIL gnt_cdb_count got %0d exp 1", got_cdb.size()); end
    else if (got_cdb[0] !== exp_cdb[0]) begin n_fail++; $display("FAIL gnt_cdb got %h exp %h", got_cdb[0], exp_cdb[0]); end
  endtask

  task automatic test_clear_load;
    sb_reset();
    issue_op(LW, 32'h1000, 32'hFFFF_FFFC, 32'h0, 4'd7);
    @(posedge clk); #1; clear = 1;
    @(posedge clk); #1; clear = 0;
    n_chk++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL clr_load_idle got busy=%b req=%b exp 0 0", busy, mem_req); end
    repeat (8) @(negedge clk);
    n_chk++;
    if (got_cdb.size() != 0) begin n_fail++; $display("FAIL clr_load_cdb got %0d pulses exp 0", got_cdb.size()); end
    @(negedge clk);
    op_type_in = LB; rs1_in = 32'h3000; imm_in = 0; tag_in = 4'd12; in_valid = 1; clear = 1;
    @(posedge clk); #1; in_valid = 0; clear = 0;
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_with_valid got busy=%b exp 0", busy); end
  endtask

  task automatic test_clear_store;
    sb_reset();
    rob_head_tag = 4'd8;
    for (int i = 0; i < 4; i++) exp_bus.push_back('{32'h5000 + i, 1'b1, 8'(8'h44 - 8'(i * 8'h11)), 32'(i + 2)});
    exp_sd.push_back('{4'd8, 32'h0, 32'd6});
    issue_op(SW, 32'h5000, 32'h0, 32'h11223344, 4'd8);
    @(posedge clk); #1;
    @(posedge clk); #1; clear = 1;
    @(posedge clk); #1; clear = 0;
    wait_idle(20);
    rob_head_tag = 4'hF;
    n_chk++;
    if (got_bus.size() != exp_bus.size()) begin n_fail++; $display("FAIL clr_st_bus_count got %0d exp %0d", got_bus.size(), exp_bus.size()); end
    foreach (exp_bus[i]) if (i < got_bus.size()) begin
      n_chk++;
      if (got_bus[i] !== exp_bus[i]) begin n_fail++; $display("FAIL clr_st_bus[%0d] got %h exp %h", i, got_bus[i], exp_bus[i]); end
    end
    n_chk++;
    if (got_sd.size() != 1) begin n_fail++; $display("FAIL clr_st_done_count got %0d exp 1", got_sd.size()); end
    else if (got_sd[0] !== exp_sd[0]) begin n_fail++; $display("FAIL clr_st_done got %h exp %h", got_sd[0], exp_sd[0]); end
  endtask

  task automatic test_rdy_freeze;
    sb_reset();
    exp_bus.push_back('{32'h3000, 1'b0, 8'h00, 32'd1});
    exp_cdb.push_back('{4'd9, 32'hFFFFFF80, 32'd5});
    issue_op(LB, 32'h3000, 32'h0, 32'h0, 4'd9);
    @(posedge clk); #1; rdy = 0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 1'b1 || mem_req !== 1'b1 || cdb_valid !== 1'b0) begin
      n_fail++; $display("FAIL rdy_hold got busy=%b req=%b cdb=%b exp 1 1 0", busy, mem_req, cdb_valid);
    end
    @(posedge clk); #1; rdy = 1;
    wait_idle(20);
    n_chk++;
    if (got_bus.size() != 1 || got_bus[0] !== exp_bus[0]) begin n_fail++; $display("FAIL rdy_bus got %0d entries exp 1 (%h)", got_bus.size(), exp_bus[0]); end
    n_chk++;
    if (got_cdb.size() != 1) begin n_fail++; $display("FAIL rdy_cdb_count got %0d exp 1", got_cdb.size()); end
    else if (got_cdb[0] !== exp_cdb[0]) begin n_fail++; $display("FAIL rdy_cdb got %h exp %h", got_cdb[0], exp_cdb[0]); end
  endtask

  task automatic test_async_reset;
    issue_op(LW, 32'h1000, 32'hFFFF_FFFC, 32'h0, 4'd10);
    @(posedge clk); #1;
    n_chk++;
    if (mem_a !== 32'hFFD) begin n_fail++; $display("FAIL arst_pre_addr got %h exp 00000ffd", mem_a); end
    #2 rst = 0;
    #1;
    n_chk++;
    if ({busy, mem_req, mem_wr, mem_a, mem_dout, cdb_valid, cdb_tag, cdb_data, store_done, store_tag} !== '0) begin
      n_fail++; $display("FAIL arst_outputs got busy=%b req=%b a=%h", busy, mem_req, mem_a);
    end
    @(negedge clk); rst = 1;
    sb_reset();
    exp_cdb.push_back('{4'd11, 32'hFFFFFF80, 32'd3});
    issue_op(LB, 32'h3000, 32'h0, 32'h0, 4'd11);
    wait_idle(20);
    n_chk++;
    if (got_cdb.size() != 1) begin n_fail++; $display("FAIL arst_lb_count got %0d exp 1", got_cdb.size()); end
    else if (got_cdb[0] !== exp_cdb[0]) begin n_fail++; $display("FAIL arst_lb got %h exp %h", got_cdb[0], exp_cdb[0]); end
  endtask

  initial begin
    rdy = 1; clear = 0; in_valid = 0; gnt_en = 1; rob_head_tag = 4'hF;
    op_type_in = 0; rs1_in = 0; rs2_in = 0; imm_in = 0; tag_in = 0;
    ram[16'h0FFC] = 8'h78; ram[16'h0FFD] = 8'h56; ram[16'h0FFE] = 8'h34; ram[16'h0FFF] = 8'h12;
    ram[16'h3000] = 8'h80; ram[16'h3001] = 8'h9A;
    ram[16'h4010] = 8'h0D; ram[16'h4011] = 8'hF0; ram[16'h4012] = 8'hFE; ram[16'h4013] = 8'hCA;
    test_reset();
    test_lw();
    test_ext();
    test_sh();
    test_gnt_toggle();
    test_clear_load();
    test_clear_store();
    test_rdy_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
